// File: rtl/qrd_rls_pkg.sv
// Shared constants and types for the QRD-RLS array and its readout logic.
package qrd_rls_pkg;

   // Default word width of the systolic array outputs.
   localparam int DATA_LENGTH_DEF = 8;
   localparam int IDX_W_DEF       = 16;
   localparam int FIFO_DEPTH_DEF  = 8;

   // Cycles by which each array output trails wxout1 for the same sample.
   localparam int W2_LAG  = 1;
   localparam int W3_LAG  = 2;
   localparam int ERR_LAG = 3;

   // Deskew depths: every word is delayed until it lines up with the error.
   localparam int W1_DLY = ERR_LAG;
   localparam int W2_DLY = ERR_LAG - W2_LAG;
   localparam int W3_DLY = ERR_LAG - W3_LAG;

   // Aligned readout vector at the default widths.
   typedef struct packed {
      logic [DATA_LENGTH_DEF-1:0] w1;
      logic [DATA_LENGTH_DEF-1:0] w2;
      logic [DATA_LENGTH_DEF-1:0] w3;
      logic [DATA_LENGTH_DEF-1:0] err;
      logic [IDX_W_DEF-1:0]       idx;
   } rls_vec_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: the head entry is always visible on rd_data_o.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop_ok, push_ok;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CW'(DEPTH));
   assign count_o   = count_q;
   assign rd_data_o = mem[rd_ptr_q];

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Next-state for pointers and occupancy.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; entries are only read once count marks them valid.
      if (push_ok) mem[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/rls_output_collector.sv
// Realigns the staggered QRD-RLS outputs into one vector per sample, tags it
// with a running index and buffers it behind a valid/ready interface.
module rls_output_collector
   import qrd_rls_pkg::*;
#(
   parameter int DATA_LENGTH = DATA_LENGTH_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int IDX_W       = IDX_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [DATA_LENGTH-1:0]        wxout1,
   input  logic [DATA_LENGTH-1:0]        wxout2,
   input  logic [DATA_LENGTH-1:0]        wxout3,
   input  logic [DATA_LENGTH-1:0]        error,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [DATA_LENGTH-1:0]        out_w1,
   output logic [DATA_LENGTH-1:0]        out_w2,
   output logic [DATA_LENGTH-1:0]        out_w3,
   output logic [DATA_LENGTH-1:0]        out_err,
   output logic [IDX_W-1:0]              out_idx,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   typedef struct packed {
      logic [DATA_LENGTH-1:0] w1;
      logic [DATA_LENGTH-1:0] w2;
      logic [DATA_LENGTH-1:0] w3;
      logic [DATA_LENGTH-1:0] err;
      logic [IDX_W-1:0]       idx;
   } vec_t;

   logic [W1_DLY-1:0]      v_q;
   logic [DATA_LENGTH-1:0] w1_q [W1_DLY];
   logic [DATA_LENGTH-1:0] w2_q [W2_DLY];
   logic [DATA_LENGTH-1:0] w3_q [W3_DLY];

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ovf_q, ovf_d;
   logic             v_al, pop, full, empty;
   vec_t             push_vec, head_vec;

   // Deskew delay lines; the valid strobe travels with wxout1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         v_q <= '0;
         for (int i = 0; i < W1_DLY; i++) w1_q[i] <= '0;
         for (int i = 0; i < W2_DLY; i++) w2_q[i] <= '0;
         for (int i = 0; i < W3_DLY; i++) w3_q[i] <= '0;
      end else begin
         v_q[0]  <= in_valid;
         w1_q[0] <= wxout1;
         w2_q[0] <= wxout2;
         w3_q[0] <= wxout3;
         for (int i = 1; i < W1_DLY; i++) begin
            v_q[i]  <= v_q[i-1];
            w1_q[i] <= w1_q[i-1];
         end
         for (int i = 1; i < W2_DLY; i++) w2_q[i] <= w2_q[i-1];
         for (int i = 1; i < W3_DLY; i++) w3_q[i] <= w3_q[i-1];
      end
   end

   // In the aligned cycle all four words belong to the same sample.
   assign v_al = v_q[W1_DLY-1];
   assign pop  = out_valid && out_ready;

   assign push_vec.w1  = w1_q[W1_DLY-1];
   assign push_vec.w2  = w2_q[W2_DLY-1];
   assign push_vec.w3  = w3_q[W3_DLY-1];
   assign push_vec.err = error;
   assign push_vec.idx = idx_q;

   // Index advances on every aligned sample, dropped or not; overflow is sticky.
   always_comb begin
      idx_d = idx_q;
      ovf_d = ovf_q;
      if (v_al) idx_d = idx_q + IDX_W'(1);
      if (v_al && full && !pop) ovf_d = 1'b1;
   end

   // Index counter and overflow flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         ovf_q <= ovf_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH ($bits(vec_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_ni    (rst),
      .push_i    (v_al),
      .wr_data_i (push_vec),
      .pop_i     (out_ready),
      .rd_data_o (head_vec),
      .count_o   (fifo_count),
      .full_o    (full),
      .empty_o   (empty)
   );

   assign out_valid = !empty;
   assign out_w1    = head_vec.w1;
   assign out_w2    = head_vec.w2;
   assign out_w3    = head_vec.w3;
   assign out_err   = head_vec.err;
   assign out_idx   = head_vec.idx;
   assign overflow  = ovf_q;

endmodule

// File: doc/rls_output_collector.md
Name: rls_output_collector

Overview:
- Sits directly downstream of the 3x3 QRD-RLS systolic top level.
- Consumes its staggered outputs: wxout1 (first), wxout2 (+1 cycle), wxout3 (+2), error (+3) per sample.
- Realigns one sample's weights and error into a single vector and tags it with a running sample index.
- Buffers vectors in a small FIFO and presents them on a valid/ready interface to the host/readout logic.

Parameters:
- DATA_LENGTH, 8, width of each weight/error word.
- FIFO_DEPTH, 8, buffered aligned vectors; power of 2, >=2.
- IDX_W, 16, width of the sample index counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset: rst==0 at a rising edge resets.
- in_valid  in  1  marks the cycle in which a sample's wxout1 is present.
- wxout1  in  DATA_LENGTH  weight 1, aligned with in_valid.
- wxout2  in  DATA_LENGTH  weight 2, valid 1 cycle after in_valid.
- wxout3  in  DATA_LENGTH  weight 3, valid 2 cycles after in_valid.
- error  in  DATA_LENGTH  a-priori error, valid 3 cycles after in_valid.
- out_ready  in  1  consumer accepts the head vector.
- out_valid  out  1  head vector available.
- out_w1, out_w2, out_w3, out_err  out  DATA_LENGTH each  aligned vector.
- out_idx  out  IDX_W  sample index of the head vector.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky; a vector was dropped.

Behaviour:
- Reset (rst==0 at an edge):
  - All delay registers, pointers, fifo_count, sample counter and overflow go to 0.
  - out_valid is 0. out_* data are don't-care while out_valid is 0.
  - Reset mid-operation discards all in-flight and buffered samples.
- Deskew:
  - wxout1 and in_valid pass through a 3-stage register delay.
  - wxout2 passes through 2 stages; wxout3 through 1 stage; error is not delayed.
  - Aligned strobe v_al = in_valid delayed 3. In that cycle all four words belong to one sample.
- Index:
  - idx_cnt increments by 1 on every v_al, wrapping modulo 2^IDX_W.
  - The stored index is the pre-increment value, so the first sample is 0.
  - Increments also on dropped samples, so gaps reveal drops.
- FIFO:
  - Show-ahead: out_* = mem[rd_ptr]; out_valid = (fifo_count != 0).
  - Pop when out_valid && out_ready.
  - Push when v_al && (!full || pop): simultaneous push+pop when full is accepted.
  - Push+pop in the same cycle leaves the count unchanged; on empty, pop cannot occur.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: v_al && full && !pop drops the vector and sets overflow, held until reset.
- Latency:
  - in_valid high in cycle c with FIFO empty gives out_valid high in cycle c+4, with that sample's data.
  - Back-to-back in_valid sustains 1 vector/cycle while out_ready=1.
- Output stability: head data and out_valid are held stable while out_valid && !out_ready.

Decomposition:
- Shared package qrd_rls_pkg:
  - DATA_LENGTH default.
  - Array latency constants: W2_LAG=1, W3_LAG=2, ERR_LAG=3. The deskew depths are derived from these.
  - Struct for the aligned vector {w1, w2, w3, err, idx}.
- One natural sub-module: sync_fifo_fwft, a parameterised show-ahead FIFO with count/full/empty, instantiated once.
- Deskew and index logic stay in the top.

Test Plan:
- Single sample: in_valid=1 at c=10 with wxout1=0x11; wxout2=0x22 at c=11, wxout3=0x33 at c=12, error=0x44 at c=13, out_ready=1 -> out_valid=1 only at c=14 with {0x11,0x22,0x33,0x44}, out_idx=0.
- Burst of 5 back-to-back samples (w1=k, w2=k+0x10, w3=k+0x20, err=k+0x30, k=1..5), out_ready=1 -> 5 consecutive out_valid cycles with exact tuples, idx 0..4, fifo_count never >1.
- Backpressure: out_ready=0, push 8 samples -> fifo_count=8, overflow=0. A 9th sample -> dropped, overflow=1, count stays 8. Release out_ready -> idx 0..7 drain in order, then the 10th sample appears with idx 9.
- Full with simultaneous pop: FIFO full, out_ready=1 in the same cycle v_al arrives -> push accepted, count stays 8, overflow stays 0.
- Reset mid-operation: rst=0 for one cycle while 3 samples are in the deskew pipe and 4 are buffered -> next cycle out_valid=0, count=0, overflow=0. The next sample emerges with idx 0.
- Index wrap: with IDX_W=4, run 17 samples -> out_idx sequence 0..15 then 0.
